// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle divider: latches operands, holds the
// divider enable and stalls the pipe until the result is captured into HI/LO.
module div_issue_ctrl #(
  parameter int DIV_LATENCY = 17,
  parameter int TIMEOUT     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_valid,
  input  logic        ex_signed,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        flush,
  input  logic        pipe_adv,
  output logic        div_ena,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_ready,
  input  logic [63:0] div_res,
  output logic        div_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        hilo_we,
  output logic        div_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  if (TIMEOUT <= DIV_LATENCY) begin : g_bad_timeout
    $error("div_issue_ctrl: TIMEOUT must exceed DIV_LATENCY");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          issue;
  logic          capture;
  logic          timeout_hit;

  always_comb begin
    state_next  = state;
    issue       = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (ex_div_valid && !flush) begin
          issue      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // flush wins over a simultaneous ready or timeout: nothing is captured
        if (flush) begin
          state_next = IDLE;
        end else if (div_ready) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          capture     = 1'b1;
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (flush || pipe_adv) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign div_ena   = (state == BUSY);
  assign div_stall = issue || (state == BUSY);
  assign hilo_we   = (state == DONE) && pipe_adv && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      div_signed  <= 1'b0;
      div_a       <= '0;
      div_b       <= '0;
      hi          <= '0;
      lo          <= '0;
      div_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (issue) begin
        div_signed <= ex_signed;
        div_a      <= ex_a;
        div_b      <= ex_b;
        cnt        <= '0;
      end else if (state == BUSY && cnt != CW'(TIMEOUT)) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) begin
        hi <= div_res[63:32];
        lo <= div_res[31:0];
      end
      if (timeout_hit) div_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized self-checking bench for div_issue_ctrl: a latency-L divider model plus a
// transaction-level reference (plain arithmetic) predicting stall, enable, HI/LO and strobe.
module tb_div_issue_ctrl;

  localparam int L       = 17;
  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_div_valid, ex_signed, flush, pipe_adv;
  logic [31:0] ex_a, ex_b;
  logic        div_ena, div_signed, div_ready, div_stall, hilo_we, div_timeout;
  logic [31:0] div_a, div_b, hi, lo;
  logic [63:0] div_res;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_hi = 0, exp_lo = 0;
  logic        exp_to = 0;
  bit          never_ready = 0;
  logic [63:0] junk = 64'h0;
  int          ena_cnt = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DIV_LATENCY(L), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_div_valid(ex_div_valid), .ex_signed(ex_signed),
    .ex_a(ex_a), .ex_b(ex_b), .flush(flush), .pipe_adv(pipe_adv),
    .div_ena(div_ena), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
    .div_ready(div_ready), .div_res(div_res), .div_stall(div_stall),
    .hi(hi), .lo(lo), .hilo_we(hilo_we), .div_timeout(div_timeout)
  );

  function automatic logic [63:0] ref_div(logic sgn, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    if (sgn) begin
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Divider environment model: ready in the L-th consecutive enabled cycle
  always @(posedge clk) ena_cnt <= div_ena ? ena_cnt + 1 : 0;
  always_comb begin
    div_ready = div_ena && (ena_cnt == L - 1) && !never_ready;
    div_res   = (div_b == 32'h0) ? junk : ref_div(div_signed, div_a, div_b);
  end

  task automatic check_val(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ex_div_valid = 1'b0;
      flush        = 1'b0;
      pipe_adv     = 1'($urandom);
      #1;
      check_val("idle_stall", div_stall, 0);
      check_val("idle_ena", div_ena, 0);
      check_val("idle_we", hilo_we, 0);
    end
  endtask

  // flush_at: -1 none, 0 in issue cycle, k in k-th BUSY cycle
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input int adv_wait, input int flush_at, input bit no_ready,
                       input bit flush_done);
    logic [63:0] expr;
    int          end_cyc;
    junk        = {$urandom, $urandom};
    expr        = (b == 32'h0) ? junk : ref_div(sgn, a, b);
    end_cyc     = no_ready ? TIMEOUT : L;
    never_ready = no_ready;

    @(negedge clk);
    ex_div_valid = 1'b1;
    ex_signed    = sgn;
    ex_a         = a;
    ex_b         = b;
    flush        = (flush_at == 0);
    pipe_adv     = 1'($urandom);
    #1;
    check_val("issue_stall", div_stall, (flush_at != 0));
    check_val("issue_ena", div_ena, 0);
    check_val("issue_we", hilo_we, 0);

    for (int i = 1; i <= end_cyc && flush_at != 0; i++) begin
      @(negedge clk);
      ex_a      = $urandom;
      ex_b      = $urandom;
      ex_signed = 1'($urandom);
      flush     = (flush_at == i);
      pipe_adv  = 1'($urandom);
      #1;
      check_val("busy_ena", div_ena, 1);
      check_val("busy_stall", div_stall, 1);
      check_val("busy_we", hilo_we, 0);
      check_val("busy_a", div_a, a);
      check_val("busy_b", div_b, b);
      check_val("busy_sgn", div_signed, sgn);
      if (flush_at == i) break;
    end

    if (flush_at >= 0 && flush_at <= end_cyc) begin
      @(negedge clk);
      ex_div_valid = 1'b0;
      flush        = 1'b0;
      #1;
      check_val("flush_ena", div_ena, 0);
      check_val("flush_stall", div_stall, 0);
      check_val("flush_we", hilo_we, 0);
      check_val("flush_hi", hi, exp_hi);
      check_val("flush_lo", lo, exp_lo);
      never_ready = 0;
      $display("op sgn=%0d a=%h b=%h flushed at %0d", sgn, a, b, flush_at);
      return;
    end

    exp_hi = expr[63:32];
    exp_lo = expr[31:0];
    if (no_ready) exp_to = 1'b1;
    for (int j = 0; j <= adv_wait; j++) begin
      @(negedge clk);
      pipe_adv = (j == adv_wait);
      flush    = flush_done && (j == adv_wait);
      #1;
      check_val("done_ena", div_ena, 0);
      check_val("done_stall", div_stall, 0);
      check_val("done_hi", hi, exp_hi);
      check_val("done_lo", lo, exp_lo);
      check_val("done_to", div_timeout, exp_to);
      check_val("done_we", hilo_we, (j == adv_wait) && !flush_done);
    end
    never_ready = 0;
    $display("op sgn=%0d a=%h b=%h -> hi=%h lo=%h to=%0d", sgn, a, b, hi, lo, div_timeout);
  endtask

  initial begin
    rst = 1'b1;
    ex_div_valid = 1'b0; ex_signed = 1'b0; ex_a = '0; ex_b = '0;
    flush = 1'b0; pipe_adv = 1'b0;
    #1;
    check_val("rst_ena", div_ena, 0);
    check_val("rst_stall", div_stall, 0);
    check_val("rst_hi", hi, 0);
    check_val("rst_lo", lo, 0);
    check_val("rst_we", hilo_we, 0);
    check_val("rst_to", div_timeout, 0);
    check_val("rst_a", div_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op(1'b1, 32'hFFFFFFF9, 32'd2, 0, -1, 0, 0);
    do_op(1'b0, 32'd100, 32'd7, 5, -1, 0, 0);
    do_op(1'b0, 32'd50, 32'd5, 0, 6, 0, 0);
    do_op(1'b1, 32'hFFFFFF9C, 32'd9, 1, -1, 0, 0);
    do_op(1'b0, 32'd10, 32'd3, 0, -1, 0, 0);
    do_op(1'b0, 32'd9, 32'd4, 0, -1, 0, 0);
    do_op(1'b0, 32'd1000, 32'd3, 2, -1, 1, 0);
    idle_cycles(1);

    // async reset in the middle of a BUSY period
    @(negedge clk);
    ex_div_valid = 1'b1; ex_signed = 1'b0; ex_a = 32'd55; ex_b = 32'd5;
    repeat (4) @(negedge clk);
    ex_div_valid = 1'b0;
    rst = 1'b1;
    #1;
    exp_hi = 0; exp_lo = 0; exp_to = 0;
    check_val("arst_ena", div_ena, 0);
    check_val("arst_stall", div_stall, 0);
    check_val("arst_hi", hi, 0);
    check_val("arst_lo", lo, 0);
    check_val("arst_to", div_timeout, 0);
    check_val("arst_a", div_a, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(1'b0, 32'd77, 32'd0, 0, -1, 0, 0);
    do_op(1'b1, 32'd12345, 32'hFFFFFFFD, 0, 0, 0, 0);
    do_op(1'b0, 32'd600, 32'd25, 1, -1, 0, 1);

    for (int n = 0; n < 40; n++) begin
      logic        sgn;
      logic [31:0] a, b;
      int          fa;
      bit          nr, fd;
      sgn = 1'($urandom);
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      fa  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, L)) : -1;
      nr  = ($urandom_range(0, 9) == 0);
      fd  = (fa < 0) && ($urandom_range(0, 9) == 0);
      do_op(sgn, a, b, int'($urandom_range(0, 3)), fa, nr, fd);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
